mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute-stage ALU in the 64-bit core.
- Latches the ALU result and store data from execute.
- Issues at most one load/store to the data memory port over a req/addr_ok/data_ok handshake.
- Aligns and extends load data, then hands the final result to write-back under the valid/allowin protocol.

Parameters:
- None. Datapath is fixed at 64 bits and the register index at 5 bits.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- es_to_ms_valid  in  1  execute stage holds a valid instruction
- ms_allowin  out  1  this stage accepts a new instruction this cycle
- es_pc  in  64  instruction PC
- es_alu_result  in  64  ALU result; effective address for memory ops
- es_store_data  in  64  store source register value
- es_mem_re  in  1  instruction is a load
- es_mem_we  in  1  instruction is a store
- es_mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword
- es_mem_unsigned  in  1  zero-extend the load (otherwise sign-extend)
- es_rf_we  in  1  instruction writes the register file
- es_dest  in  5  destination register
- data_req  out  1  memory request valid
- data_wr  out  1  1 = store
- data_size  out  2  equal to the latched mem_size
- data_addr  out  64  latched alu_result
- data_wstrb  out  8  byte write enables
- data_wdata  out  64  replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response complete
- data_rdata  in  64  load data (aligned 8-byte word)
- ms_to_ws_valid  out  1  result valid to write-back
- ws_allowin  in  1  write-back accepts
- ms_pc  out  64  latched PC
- ms_rf_we  out  1  register write enable (already qualified by ms_valid)
- ms_dest  out  5  destination register
- ms_final_result  out  64  load data, or the ALU result for non-memory ops

Behaviour:
- Reset (async, resetn=0):
  - ms_valid=0, state=IDLE, all latched fields=0.
  - Outputs: data_req=0, ms_to_ws_valid=0, ms_rf_we=0, ms_allowin=1, ms_final_result=0.
- Handshake:
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - On a rising edge with es_to_ms_valid & ms_allowin, all es_* fields are latched and ms_valid is set.
  - If ms_allowin=1 and es_to_ms_valid=0, ms_valid is cleared.
  - ms_to_ws_valid = ms_valid & ms_ready_go.
- State machine:
  - IDLE: instruction latched with re|we -> REQ. Latched non-memory op -> DONE.
  - REQ: data_req=1. Address, size, wstrb and wdata stay stable until data_addr_ok. On addr_ok -> WAIT.
  - WAIT: data_req=0. On data_data_ok, a load captures the extracted rdata into the result register -> DONE. A store simply -> DONE.
  - DONE: ms_ready_go=1. If ws_allowin, the transfer completes; the next state is REQ, DONE or IDLE according to the newly latched instruction (IDLE if none).
- Outstanding requests: only one at a time. data_data_ok is never expected in the same cycle as data_addr_ok; a data_ok in IDLE/REQ/DONE is ignored.
- Latency:
  - Non-memory op: ready the cycle after it is latched.
  - Memory op: minimum 3 cycles (REQ, WAIT, DONE).
  - Back-to-back non-memory ops sustain 1 per cycle.
- Store encoding (off = addr[2:0]):
  - wstrb: byte = 0x01<<off; half = 0x03<<off; word = 0x0F<<off; dword = 0xFF. Shifts are truncated to 8 bits.
  - wdata: byte replicated ×8, half ×4, word ×2, dword as-is.
- Load extraction:
  - shifted = rdata >> (off*8).
  - Take the low 8/16/32/64 bits per size, then zero-extend if mem_unsigned else sign-extend to 64.
- ms_final_result = captured load value for loads; latched alu_result otherwise (stores included).
- ms_rf_we = ms_valid & latched rf_we.
- Write-back stall in DONE: all outputs hold and ms_allowin=0.
- Reset mid-transaction: the state returns to IDLE immediately, and a pending data_ok after reset is ignored.

Optional Feature:
- MS_ALIGN_CHECK_EN defined: adds output ms_ex_ale (1 bit, reset 0).
  - Misaligned access: half with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0.
  - On a misaligned access, no data_req is ever raised; the state goes IDLE->DONE directly.
  - ms_ex_ale=1 while the instruction is in DONE, and ms_rf_we is forced to 0.
- Undefined: the port is absent and misaligned addresses are issued unchanged, using the shift/truncate rules above.

Test Plan:
- Non-memory stream, ALU results 0x11, 0x22, 0x33 on consecutive cycles, ws_allowin=1 -> ms_final_result shows 0x11, 0x22, 0x33 on 3 consecutive cycles; data_req never asserted.
- Signed byte load, addr 0x1003, rdata 0x0000_0000_8000_0000 -> data_size=0; after data_ok, ms_final_result=0xFFFF_FFFF_FFFF_FF80. The same access with unsigned=1 -> 0x80.
- Half store, addr 0x2006, data 0xABCD, addr_ok delayed 3 cycles -> data_req held 3+1 cycles with stable signals, data_wstrb=0xC0, data_wdata=0xABCD_ABCD_ABCD_ABCD, ms_rf_we=0.
- Word load completes while ws_allowin=0 for 2 cycles -> stays in DONE with stable outputs and ms_allowin=0. On ws_allowin=1 the next es instruction is accepted in the same cycle.
- resetn pulsed low while in WAIT, followed by a late data_ok -> all outputs at reset values, the data_ok is ignored, and the next instruction issues normally.
- MS_ALIGN_CHECK_EN: word load at addr 0x3002 -> no data_req, ms_ex_ale=1, ms_rf_we=0, ready the next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: latches execute results, issues one load/store, aligns load data for write-back.
// Optional MS_ALIGN_CHECK_EN: flags misaligned accesses on ms_ex_ale instead of issuing them.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [63:0] es_pc,
    input  logic [63:0] es_alu_result,
    input  logic [63:0] es_store_data,
    input  logic        es_mem_re,
    input  logic        es_mem_we,
    input  logic [1:0]  es_mem_size,
    input  logic        es_mem_unsigned,
    input  logic        es_rf_we,
    input  logic [4:0]  es_dest,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [63:0] data_addr,
    output logic [7:0]  data_wstrb,
    output logic [63:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [63:0] data_rdata,
    output logic        ms_to_ws_valid,
    input  logic        ws_allowin,
    output logic [63:0] ms_pc,
    output logic        ms_rf_we,
    output logic [4:0]  ms_dest,
    output logic [63:0] ms_final_result
`ifdef MS_ALIGN_CHECK_EN
    ,
    output logic        ms_ex_ale
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state;
    logic        ms_valid;
    logic        ms_ready_go;
    logic [63:0] pc_r, alu_r, sd_r, result_r;
    logic        re_r, we_r, uns_r, rf_we_r, ale_r;
    logic [1:0]  size_r;
    logic [4:0]  dest_r;
    logic        es_ale;
    logic [2:0]  off;
    logic [63:0] shifted, load_val;

`ifdef MS_ALIGN_CHECK_EN
    logic es_misalign;
    always_comb begin
        case (es_mem_size)
            2'd1:    es_misalign = es_alu_result[0];
            2'd2:    es_misalign = |es_alu_result[1:0];
            2'd3:    es_misalign = |es_alu_result[2:0];
            default: es_misalign = 1'b0;
        endcase
    end
    assign es_ale    = (es_mem_re | es_mem_we) & es_misalign;
    assign ms_ex_ale = ms_valid & ale_r & (state == S_DONE);
`else
    assign es_ale = 1'b0;
`endif

    assign ms_ready_go    = (state == S_DONE);
    assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    assign ms_rf_we       = ms_valid & rf_we_r & !ale_r;
    assign ms_pc          = pc_r;
    assign ms_dest        = dest_r;
    assign ms_final_result = result_r;

    assign data_req  = ms_valid & (state == S_REQ);
    assign data_wr   = we_r;
    assign data_size = size_r;
    assign data_addr = alu_r;
    assign off       = alu_r[2:0];

    // Strobes shift within the 8-byte word; bytes past lane 7 are dropped.
    always_comb begin
        case (size_r)
            2'd0:    begin data_wstrb = 8'h01 << off; data_wdata = {8{sd_r[7:0]}};  end
            2'd1:    begin data_wstrb = 8'h03 << off; data_wdata = {4{sd_r[15:0]}}; end
            2'd2:    begin data_wstrb = 8'h0F << off; data_wdata = {2{sd_r[31:0]}}; end
            default: begin data_wstrb = 8'hFF;        data_wdata = sd_r;            end
        endcase
    end

    assign shifted = data_rdata >> {off, 3'b000};
    always_comb begin
        case (size_r)
            2'd0:    load_val = uns_r ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1:    load_val = uns_r ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    load_val = uns_r ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            ms_valid <= 1'b0;
            pc_r     <= '0;
            alu_r    <= '0;
            sd_r     <= '0;
            result_r <= '0;
            re_r     <= 1'b0;
            we_r     <= 1'b0;
            uns_r    <= 1'b0;
            rf_we_r  <= 1'b0;
            ale_r    <= 1'b0;
            size_r   <= '0;
            dest_r   <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            ms_valid <= 1'b1;
            pc_r     <= es_pc;
            alu_r    <= es_alu_result;
            sd_r     <= es_store_data;
            result_r <= es_alu_result;
            re_r     <= es_mem_re;
            we_r     <= es_mem_we;
            uns_r    <= es_mem_unsigned;
            rf_we_r  <= es_rf_we;
            ale_r    <= es_ale;
            size_r   <= es_mem_size;
            dest_r   <= es_dest;
            // Next state is chosen from the incoming op so non-memory ops are ready next cycle.
            state    <= ((es_mem_re | es_mem_we) & !es_ale) ? S_REQ : S_DONE;
        end else if (ms_allowin) begin
            ms_valid <= 1'b0;
            state    <= S_IDLE;
        end else begin
            case (state)
                S_REQ:  if (data_addr_ok) state <= S_WAIT;
                S_WAIT: if (data_data_ok) begin
                    if (re_r) result_r <= load_val;
                    state <= S_DONE;
                end
                default: ;
            endcase
        end
    end
endmodule
